load_store_unit: RTL and testbench

- Memory-access stage between the CPU execute stage and the word-addressed data memory (`dataMem`, array `memoria`).
- Performs RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW on a 32-bit little-endian data memory.
- Sub-word stores use a read-modify-write sequence.
- Misaligned accesses and illegal funct3 codes are reported back to the pipeline without touching memory.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_load_extract.sv | 30 +++
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state encoding,
// byte-lane width and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        RESP   = 3'd4
    } lsu_state_e;

    // Stores only support B/H/W; loads additionally allow the unsigned forms.
    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3)
            F3_H, F3_HU: mis = off[0];
            F3_W:        mis = (off != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load data extraction: selects the addressed byte/halfword lane of a
// little-endian word and sign- or zero-extends it according to funct3.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [BYTE_W-1:0]   byte_sel;
    logic [2*BYTE_W-1:0] half_sel;

    // Lane select followed by width-dependent extension.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: BYTE_W];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = 32'h0;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            F3_W:    data_o = word_i;
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory.
// Sub-word stores use read-modify-write unless LSU_BYTE_STROBE_EN is defined, in which
// case a mem_be lane-enable port is added and SB/SH become single write accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned MEM_ADDR_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [2:0]                req_funct3,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      resp_valid,
    output logic [31:0]               resp_rdata,
    output logic                      resp_error,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
`ifdef LSU_BYTE_STROBE_EN
    output logic [3:0]                mem_be,
`endif
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ready
);

    lsu_state_e                state_q, state_d;
    logic                      write_q;
    logic [2:0]                funct3_q;
    logic [MEM_ADDR_WIDTH+1:0] addr_q;
    logic [31:0]               wdata_q;
    logic [31:0]               rdata_q;
    logic                      err_q;
    logic [31:0]               load_data;
    logic                      handshake;
    logic                      req_bad;
    logic                      unused_addr;

    // Address bits above the memory index are deliberately dropped (accesses wrap).
    assign unused_addr = ^req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

    assign handshake = req_valid && req_ready;
    assign req_bad   = !f3_legal(req_write, req_funct3)
                     || f3_misaligned(req_funct3, req_addr[1:0]);

    lsu_load_extract u_extract (
        .word_i   (mem_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // Next-state selection for the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (req_bad) begin
                        state_d = RESP;
`ifndef LSU_BYTE_STROBE_EN
                    end else if (req_write && (req_funct3 == F3_B || req_funct3 == F3_H)) begin
                        state_d = RMW_RD;
`endif
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS:  if (mem_ready) state_d = RESP;
            RMW_RD:  if (mem_ready) state_d = RMW_WR;
            RMW_WR:  if (mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight access immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture at handshake and load result capture on memory completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else if (handshake) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[MEM_ADDR_WIDTH+1:0];
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_bad;
        end else if (state_q == ACCESS && mem_ready && !write_q) begin
            rdata_q  <= load_data;
        end
    end

`ifdef LSU_BYTE_STROBE_EN
    logic [31:0] store_word;
    logic [3:0]  store_be;

    // Replicate store data across lanes; mem_be picks the lane(s) actually written.
    always_comb begin
        store_word = wdata_q;
        store_be   = 4'b1111;
        case (funct3_q)
            F3_B: begin
                store_word = {4{wdata_q[7:0]}};
                store_be   = 4'b0001 << addr_q[1:0];
            end
            F3_H: begin
                store_word = {2{wdata_q[15:0]}};
                store_be   = 4'b0011 << addr_q[1:0];
            end
            default: begin
                store_word = wdata_q;
                store_be   = 4'b1111;
            end
        endcase
    end

    assign mem_be = (state_q == ACCESS && write_q) ? store_be : 4'b0000;

    // Memory write data, only driven while an access is active.
    always_comb begin
        mem_wdata = 32'h0;
        if (state_q == ACCESS) mem_wdata = store_word;
    end
`else
    logic [31:0] merged_q;
    logic [31:0] merge_word;

    // Insert the store byte/halfword into the word just read back.
    always_comb begin
        merge_word = mem_rdata;
        if (funct3_q == F3_B) begin
            merge_word[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[7:0];
        end else begin
            merge_word[{addr_q[1], 4'b0000} +: 2*BYTE_W] = wdata_q[15:0];
        end
    end

    // Hold the merged word for the write-back half of the RMW.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            merged_q <= 32'h0;
        end else if (state_q == RMW_RD && mem_ready) begin
            merged_q <= merge_word;
        end
    end

    // Memory write data, only driven while an access is active.
    always_comb begin
        mem_wdata = 32'h0;
        case (state_q)
            ACCESS:  mem_wdata = wdata_q;
            RMW_WR:  mem_wdata = merged_q;
            default: mem_wdata = 32'h0;
        endcase
    end
`endif

    assign req_ready  = (state_q == IDLE);
    assign mem_en     = (state_q == ACCESS) || (state_q == RMW_RD) || (state_q == RMW_WR);
    assign mem_we     = (state_q == ACCESS && write_q) || (state_q == RMW_WR);
    assign mem_addr   = addr_q[MEM_ADDR_WIDTH+1:2];
    assign resp_valid = (state_q == RESP);
    assign resp_error = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0]  mem_be;
    localparam int SUB = 2;
`else
    localparam int SUB = 3;
`endif

    logic [31:0] memoria [256];
    logic        mem_clr;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    logic        ready_ctl;

    int checks;
    int failures;

    load_store_unit dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
`ifdef LSU_BYTE_STROBE_EN
        .mem_be     (mem_be),
`endif
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = memoria[mem_addr];
    assign mem_ready = ready_ctl;

    // Behavioural memory: clear, preload, or accept a completed write.
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) memoria[i] <= 32'h0;
        end else if (pre_we) begin
            memoria[pre_idx] <= pre_val;
        end else if (mem_en && mem_we && mem_ready) begin
`ifdef LSU_BYTE_STROBE_EN
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) memoria[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
`else
            memoria[mem_addr] <= mem_wdata;
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clock);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge clock);
        pre_we  = 1'b0;
    endtask

    // Issue one request, return response fields and latency from the handshake edge.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat, output logic en_seen, output logic [3:0] be);
        int guard;
        rd = 32'h0; err = 1'b0; lat = 0; en_seen = 1'b0; be = 4'b0000;
        @(negedge clock);
        req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'h0, req_ready}, 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            if (mem_en) en_seen = 1'b1;
`ifdef LSU_BYTE_STROBE_EN
            if (mem_en && mem_we) be = mem_be;
`endif
            @(posedge clock);
            #1;
            lat++;
        end
        if (!resp_valid) check("resp_timeout", {31'h0, resp_valid}, 32'h1);
        rd  = resp_rdata;
        err = resp_error;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_mem2;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic        en_seen;
        logic [3:0]  be;
        logic        busy_bad;

        checks = 0; failures = 0;
        reset = 1'b1; mem_clr = 1'b1; pre_we = 1'b0; pre_idx = 8'h0; pre_val = 32'h0;
        ready_ctl = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;

        vecs[0]  = '{1'b0, 3'b010, 32'h8,   32'h0,        32'h8081_7F10, 1'b0, 2,   32'h8081_7F10};
        vecs[1]  = '{1'b0, 3'b000, 32'hA,   32'h0,        32'hFFFF_FF81, 1'b0, 2,   32'h8081_7F10};
        vecs[2]  = '{1'b0, 3'b100, 32'hA,   32'h0,        32'h0000_0081, 1'b0, 2,   32'h8081_7F10};
        vecs[3]  = '{1'b0, 3'b001, 32'hA,   32'h0,        32'hFFFF_8081, 1'b0, 2,   32'h8081_7F10};
        vecs[4]  = '{1'b0, 3'b101, 32'hA,   32'h0,        32'h0000_8081, 1'b0, 2,   32'h8081_7F10};
        vecs[5]  = '{1'b0, 3'b000, 32'h8,   32'h0,        32'h0000_0010, 1'b0, 2,   32'h8081_7F10};
        vecs[6]  = '{1'b0, 3'b001, 32'h8,   32'h0,        32'h0000_7F10, 1'b0, 2,   32'h8081_7F10};
        vecs[7]  = '{1'b0, 3'b000, 32'h9,   32'h0,        32'h0000_007F, 1'b0, 2,   32'h8081_7F10};
        vecs[8]  = '{1'b0, 3'b001, 32'h5,   32'h0,        32'h0,         1'b1, 1,   32'h8081_7F10};
        vecs[9]  = '{1'b0, 3'b011, 32'h8,   32'h0,        32'h0,         1'b1, 1,   32'h8081_7F10};
        vecs[10] = '{1'b1, 3'b100, 32'h8,   32'hFFFF_FFFF, 32'h0,        1'b1, 1,   32'h8081_7F10};
        vecs[11] = '{1'b1, 3'b010, 32'h6,   32'hFFFF_FFFF, 32'h0,        1'b1, 1,   32'h8081_7F10};
        vecs[12] = '{1'b1, 3'b000, 32'h9,   32'h0000_0055, 32'h0,        1'b0, SUB, 32'h8081_5510};
        vecs[13] = '{1'b0, 3'b010, 32'h8,   32'h0,        32'h8081_5510, 1'b0, 2,   32'h8081_5510};
        vecs[14] = '{1'b1, 3'b001, 32'hA,   32'h1234_ABCD, 32'h0,        1'b0, SUB, 32'hABCD_5510};
        vecs[15] = '{1'b0, 3'b010, 32'h408, 32'h0,        32'hABCD_5510, 1'b0, 2,   32'hABCD_5510};
        vecs[16] = '{1'b0, 3'b001, 32'hB,   32'h0,        32'h0,         1'b1, 1,   32'hABCD_5510};
        vecs[17] = '{1'b0, 3'b100, 32'hB,   32'h0,        32'h0000_00AB, 1'b0, 2,   32'hABCD_5510};
        vecs[18] = '{1'b0, 3'b000, 32'hB,   32'h0,        32'hFFFF_FFAB, 1'b0, 2,   32'hABCD_5510};

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_error", {31'h0, resp_error}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_mem_en",     {31'h0, mem_en},     32'h0);
        check("rst_mem_we",     {31'h0, mem_we},     32'h0);
        check("rst_mem_addr",   {24'h0, mem_addr},   32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        @(negedge clock);
        reset = 1'b0; mem_clr = 1'b0;
        preload(8'd2, 32'h8081_7F10);

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, en_seen, be);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_error", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_mem_en_seen", i), {31'h0, en_seen}, {31'h0, !vecs[i].exp_err});
            check($sformatf("v%0d_mem2", i), memoria[2], vecs[i].exp_mem2);
`ifdef LSU_BYTE_STROBE_EN
            if (i == 12) check("sb_mem_be", {28'h0, be}, 32'h2);
            if (i == 14) check("sh_mem_be", {28'h0, be}, 32'hC);
            if (i == 13) check("lw_mem_be", {28'h0, be}, 32'h0);
`endif
        end

        // SW with three memory wait cycles and a competing request held during busy
        @(negedge clock);
        ready_ctl = 1'b0;
        req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h4; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_addr = 32'h20; req_wdata = 32'h1111_1111;
        busy_bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (!mem_en || !mem_we || mem_addr != 8'd1 || mem_wdata != 32'hDEAD_BEEF || resp_valid)
                busy_bad = 1'b1;
            if (c < 3) begin
                @(posedge clock);
                #1;
            end
        end
        check("stall_signals_stable", {31'h0, busy_bad}, 32'h0);
        ready_ctl = 1'b1;
        @(posedge clock);
        #1;
        check("stall_resp_n5", {31'h0, resp_valid}, 32'h1);
        req_valid = 1'b0;
        busy_bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            if (resp_valid || mem_en) busy_bad = 1'b1;
        end
        check("busy_req_ignored", {31'h0, busy_bad}, 32'h0);
        check("stall_mem1", memoria[1], 32'hDEAD_BEEF);
        check("stall_mem8", memoria[8], 32'h0);

        // Reset in the middle of an SH
        @(negedge clock);
        ready_ctl = 1'b0;
        req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h8; req_wdata = 32'h0000_7777;
        req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("mid_mem_en_active", {31'h0, mem_en}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_mem_en", {31'h0, mem_en},     32'h0);
        check("mid_rst_mem_we", {31'h0, mem_we},     32'h0);
        check("mid_rst_resp",   {31'h0, resp_valid}, 32'h0);
        ready_ctl = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_mem2",  memoria[2], 32'hABCD_5510);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, rd, err, lat, en_seen, be);
        check("post_rst_lw", rd, 32'hABCD_5510);
        check("post_rst_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
